// File: rtl/demux_stream_if.sv
// Handshake bundle for demux_stream: one select-addressed input stream
// and N one-hot output channels with per-channel ready.
interface demux_stream_if #(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 1
);
  localparam int N = 1 << SEL_W;

  logic                in_valid;
  logic                in_ready;
  logic [SEL_W-1:0]    in_sel;
  logic [DATA_W-1:0]   in_data;
  logic [N-1:0]        out_valid;
  logic [N-1:0]        out_ready;
  logic [N*DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_stream.sv
// Registered 1:2^SEL_W demux; optional channel-scan sequencer under DEMUX_STREAM_SCAN_EN.
// Latency: 1 cycle from input accept to out_valid; 1 word/cycle sustained.
// Backpressure: in_ready drops while the held word's consumer is not ready (and during a scan).
module demux_stream #(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_stream_if.slave bus,
  input  logic         scan_start,
  output logic         scan_busy
);
  localparam int N = 1 << SEL_W;

  logic              full;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] data_q;
  logic              room;
  logic              ld_vld;
  logic [SEL_W-1:0]  ld_sel;
  logic [DATA_W-1:0] ld_dat;

  // Room for a new word: empty, or the held word leaves this same cycle.
  assign room = !full || bus.out_ready[sel_q];

`ifdef DEMUX_STREAM_SCAN_EN
  typedef enum logic {IDLE, SCAN} state_t;
  state_t            state, state_nxt;
  logic [SEL_W-1:0]  cnt;
  logic [DATA_W-1:0] scan_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (scan_start)     state_nxt = SCAN;
      SCAN: if (room && &cnt)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    scan_busy    = (state == SCAN);
    bus.in_ready = !scan_busy && room;
    ld_vld       = scan_busy ? room : (bus.in_valid && room);
    ld_sel       = scan_busy ? cnt : bus.in_sel;
    ld_dat       = scan_busy ? scan_data : bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      scan_data <= '0;
    end else if (state == IDLE && scan_start) begin
      cnt       <= '0;
      scan_data <= bus.in_data;
    end else if (state == SCAN && room && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_scan_start;
  assign unused_scan_start = scan_start;
  assign scan_busy    = 1'b0;
  assign bus.in_ready = room;
  assign ld_vld       = bus.in_valid && room;
  assign ld_sel       = bus.in_sel;
  assign ld_dat       = bus.in_data;
`endif

  // A load always wins over a drain, so a pass-through keeps full set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else if (ld_vld) begin
      full   <= 1'b1;
      sel_q  <= ld_sel;
      data_q <= ld_dat;
    end else if (full && bus.out_ready[sel_q]) begin
      full <= 1'b0;
    end
  end

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int k = 0; k < N; k++) begin
      if (full && sel_q == SEL_W'(k)) begin
        bus.out_valid[k]                  = 1'b1;
        bus.out_data[k*DATA_W +: DATA_W]  = data_q;
      end
    end
  end
endmodule

// File: tb/tb_demux_stream.sv
// Randomised and directed bench for demux_stream against a word-level reference model.
module tb_demux_stream;
  localparam int SEL_W  = 4;
  localparam int DATA_W = 8;
  localparam int N      = 16;
  localparam int W      = N * DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scan_start = 1'b0;
  logic scan_busy;

  demux_stream_if #(.SEL_W(SEL_W), .DATA_W(DATA_W)) bus ();

  demux_stream #(.SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .scan_start (scan_start),
    .scan_busy  (scan_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the held word plus the number of scan words still to issue.
  bit               m_full;
  logic [SEL_W-1:0] m_sel;
  logic [7:0]       m_dat;
  int               m_left;
  logic [7:0]       m_sdat;
  logic [N-1:0]     e_valid;
  logic [W-1:0]     e_data;
  bit               e_busy, e_room;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", W'(bus.out_valid), '0);
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_scan_busy", W'(scan_busy), '0);
      m_full = 0; m_sel = '0; m_dat = '0; m_left = 0; m_sdat = '0;
    end else begin
      e_valid = '0;
      e_data  = '0;
      if (m_full) begin
        e_valid[m_sel] = 1'b1;
        e_data[m_sel*DATA_W +: DATA_W] = m_dat;
      end
      e_busy = (m_left > 0);
      e_room = !m_full || bus.out_ready[m_sel];
      chk("out_valid", W'(bus.out_valid), W'(e_valid));
      chk("out_data", bus.out_data, e_data);
      chk("in_ready", W'(bus.in_ready), W'(!e_busy && e_room));
      chk("scan_busy", W'(scan_busy), W'(e_busy));
      if (e_busy) begin
        if (e_room) begin
          m_full = 1; m_sel = SEL_W'(N - m_left); m_dat = m_sdat; m_left--;
        end
      end else begin
        if (bus.in_valid && e_room) begin
          m_full = 1; m_sel = bus.in_sel; m_dat = bus.in_data;
        end else if (m_full && bus.out_ready[m_sel]) begin
          m_full = 0;
        end
`ifdef DEMUX_STREAM_SCAN_EN
        if (scan_start) begin
          m_left = N; m_sdat = bus.in_data;
        end
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain();
    bus.in_valid = 0; scan_start = 0; bus.out_ready = '1;
    repeat (40) cyc();
  endtask

  int ch, busy_n, stall, seen;
  logic [N-1:0] prev;

  initial begin
    bus.in_valid = 0; bus.in_sel = '0; bus.in_data = '0; bus.out_ready = '1;
    repeat (3) cyc();
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", W'(bus.in_ready), W'(1));
    chk("valid_after_reset", W'(bus.out_valid), '0);

    // Sweep all channels back to back
    for (int k = 0; k <= N; k++) begin
      cyc();
      if (k < N) begin
        bus.in_valid = 1; bus.in_sel = SEL_W'(k); bus.in_data = 8'(8'hA0 + k);
      end else bus.in_valid = 0;
      @(negedge clk);
      if (k > 0) begin
        chk("sweep_valid", W'(bus.out_valid), W'(16'h1 << (k - 1)));
        chk("sweep_lane", W'(bus.out_data[(k-1)*8 +: 8]), W'(8'hA0 + k - 1));
      end
    end

    // Back-pressure on channel 5; channel 6 ready must not matter
    cyc();
    bus.in_valid = 1; bus.in_sel = 4'd5; bus.in_data = 8'h3C; bus.out_ready = '1; bus.out_ready[5] = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.in_sel = 4'd1; bus.in_data = 8'h11; bus.out_ready[6] = i[0];
      @(negedge clk);
      chk("bp_valid", W'(bus.out_valid), W'(16'h0020));
      chk("bp_ready", W'(bus.in_ready), '0);
      chk("bp_lane", W'(bus.out_data[5*8 +: 8]), W'(8'h3C));
    end
    cyc();
    bus.out_ready = '1;
    @(negedge clk);
    chk("bp_release_ready", W'(bus.in_ready), W'(1));
    cyc();
    bus.in_valid = 0;
    @(negedge clk);
    chk("bp_next_valid", W'(bus.out_valid), W'(16'h0002));

    // Pass-through: held word on ch2 replaced by ch9 without a bubble
    cyc();
    bus.in_valid = 1; bus.in_sel = 4'd2; bus.in_data = 8'h22;
    cyc();
    bus.in_sel = 4'd9; bus.in_data = 8'h55;
    @(negedge clk);
    chk("pt_valid_a", W'(bus.out_valid), W'(16'h0004));
    cyc();
    bus.in_valid = 0;
    @(negedge clk);
    chk("pt_valid_b", W'(bus.out_valid), W'(16'h0200));
    chk("pt_lane", W'(bus.out_data[9*8 +: 8]), W'(8'h55));

    // Random traffic, including occasional scan requests
    for (int i = 0; i < 400; i++) begin
      cyc();
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_sel   = SEL_W'($urandom_range(0, N - 1));
      bus.in_data  = 8'($urandom);
      scan_start   = ($urandom_range(0, 59) == 0);
      for (int b = 0; b < N; b++) bus.out_ready[b] = ($urandom_range(0, 3) != 0);
    end

    // Reset mid-traffic with a word held
    cyc();
    scan_start = 0; bus.in_valid = 1; bus.in_sel = 4'd3; bus.in_data = 8'h9A;
    cyc();
    bus.in_valid = 0; bus.out_ready = '0;
    rst_n = 0;
    #1;
    chk("midrst_valid", W'(bus.out_valid), '0);
    chk("midrst_data", bus.out_data, '0);
    chk("midrst_busy", W'(scan_busy), '0);
    cyc();
    rst_n = 1; bus.out_ready = '1;
    @(negedge clk);
    chk("midrst_ready", W'(bus.in_ready), W'(1));
    idle_drain();

`ifdef DEMUX_STREAM_SCAN_EN
    // Full scan with all consumers ready
    scan_start = 1; bus.in_data = 8'h7E;
    cyc();
    scan_start = 0; bus.in_data = 8'h00;
    ch = 0; busy_n = 0; prev = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (scan_busy) begin
        busy_n++;
        chk("scan_in_ready", W'(bus.in_ready), '0);
      end
      if (bus.out_valid != 0 && bus.out_valid != prev) begin
        chk("scan_step", W'(bus.out_valid), W'(16'h1 << ch));
        chk("scan_lane", W'(bus.out_data[ch*8 +: 8]), W'(8'h7E));
        ch++;
      end
      prev = bus.out_valid;
    end
    chk("scan_busy_cycles", W'(busy_n), W'(16));
    chk("scan_channels", W'(ch), W'(16));
    idle_drain();

    // Scan with channel 7 stalled for three cycles
    scan_start = 1; bus.in_data = 8'h7E;
    cyc();
    scan_start = 0;
    busy_n = 0; stall = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (scan_busy) busy_n++;
      if (stall >= 0 && !bus.out_ready[7]) begin
        stall++;
        if (stall == 3) begin #1; bus.out_ready[7] = 1; end
      end else if (stall < 0 && bus.out_valid == 16'h0080) begin
        #1; bus.out_ready[7] = 0; stall = 0;
      end
    end
    chk("stall_busy_cycles", W'(busy_n), W'(19));
    idle_drain();

    // Abort a scan with reset at step 6, then restart
    scan_start = 1; bus.in_data = 8'h42;
    cyc();
    scan_start = 0;
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.out_valid == 16'h0040) seen = 1;
    end
    chk("abort_reached_step6", W'(seen), W'(1));
    #1; rst_n = 0;
    #1;
    chk("abort_valid", W'(bus.out_valid), '0);
    chk("abort_busy", W'(scan_busy), '0);
    cyc();
    rst_n = 1;
    cyc();
    scan_start = 1; bus.in_data = 8'h24;
    cyc();
    scan_start = 0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.out_valid != 0) begin
        seen = 1;
        chk("restart_first", W'(bus.out_valid), W'(16'h0001));
        chk("restart_lane", W'(bus.out_data[7:0]), W'(8'h24));
      end
    end
    chk("restart_seen", W'(seen), W'(1));
    idle_drain();
`else
    // Scan request is inert without the sequencer
    scan_start = 1; bus.in_data = 8'h7E;
    cyc();
    scan_start = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("noscan_busy", W'(scan_busy), '0);
      chk("noscan_valid", W'(bus.out_valid), '0);
      chk("noscan_ready", W'(bus.in_ready), W'(1));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
